data_memory_unit: RTL and testbench

- Responder end of the memory-stage data interface.
- Accepts one read, write, push or pop per transaction and drives read data back.
- Owns the stack pointer (SP) and a word-addressed data RAM.
- Multi-cycle access with a busy/done handshake, so the pipeline can stall on memory ops.

---
 rtl/data_memory_unit.sv | 177 +++++++++++++++++
 tb/tb_data_memory_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Memory-stage data responder: word RAM plus stack pointer behind a busy/done handshake.
// Optional build macro STACK_BOUNDS_CHECK_EN blocks push at SP==0 and pop at SP==SP_RESET.
module data_memory_unit #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int LATENCY  = 2,
  parameter int SP_RESET = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic              memory_push,
  input  logic              memory_pop,
  input  logic [15:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] data_r,
  output logic              busy,
  output logic              done,
  output logic              op_error,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_fault,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(SP_RESET);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] sp;
  logic              fault_q;

  logic [2:0]        req_cnt;
  logic              one_op;
  logic              multi_op;
  op_t               req_op;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;
  logic              last_access;
  logic              overflow;
  logic              underflow;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^address[15:ADDR_W];

  assign req_cnt  = 3'(memory_read) + 3'(memory_write) + 3'(memory_push) + 3'(memory_pop);
  assign one_op   = (req_cnt == 3'd1);
  assign multi_op = (req_cnt > 3'd1);

  always_comb begin
    req_op = OP_READ;
    if (memory_write)     req_op = OP_WRITE;
    else if (memory_push) req_op = OP_PUSH;
    else if (memory_pop)  req_op = OP_POP;
  end

  // SP arithmetic wraps modulo 2^ADDR_W by construction of the width.
  assign sp_inc = sp + ADDR_W'(1);
  assign sp_dec = sp - ADDR_W'(1);

  assign last_access = (state == S_ACCESS) && (cnt == '0);

`ifdef STACK_BOUNDS_CHECK_EN
  assign overflow  = (op_q == OP_PUSH) && (sp == '0);
  assign underflow = (op_q == OP_POP) && (sp == SP_TOP);
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // A reset on the committing edge must leave the RAM untouched.
  assign mem_we    = last_access && !rst &&
                     ((op_q == OP_WRITE) || ((op_q == OP_PUSH) && !overflow));
  assign mem_waddr = (op_q == OP_PUSH) ? sp : addr_q;
  assign mem_raddr = (op_q == OP_POP) ? sp_inc : addr_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      sp       <= SP_TOP;
      data_r   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_error <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          fault_q  <= 1'b0;
          op_error <= multi_op;
          if (one_op) begin
            op_q    <= req_op;
            addr_q  <= address[ADDR_W-1:0];
            wdata_q <= write_data;
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          op_error <= 1'b0;
          if (cnt == '0) begin
            case (op_q)
              OP_READ:  data_r <= mem[mem_raddr];
              OP_WRITE: ;
              OP_PUSH:  if (!overflow) sp <= sp_dec;
              OP_POP: begin
                if (!underflow) begin
                  data_r <= mem[mem_raddr];
                  sp     <= sp_inc;
                end
              end
              default: ;
            endcase
            fault_q <= overflow || underflow;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          // Requests are deliberately ignored here; the initiator updates them on this edge.
          done     <= 1'b0;
          fault_q  <= 1'b0;
          op_error <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sp_out      = sp;
  assign stack_fault = fault_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: vector table for the main transactions plus
// hand-written sequences for conflicts, reset mid-access and stack bounds.
module tb_data_memory_unit;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 16;
  localparam int LATENCY = 2;

  localparam logic [3:0] OP_RD   = 4'b1000;
  localparam logic [3:0] OP_WR   = 4'b0100;
  localparam logic [3:0] OP_PUSH = 4'b0010;
  localparam logic [3:0] OP_POP  = 4'b0001;

  logic              clk = 1'b0;
  logic              rst;
  logic              memory_read;
  logic              memory_write;
  logic              memory_push;
  logic              memory_pop;
  logic [15:0]       address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] data_r;
  logic              busy;
  logic              done;
  logic              op_error;
  logic [ADDR_W-1:0] sp_out;
  logic              stack_fault;
  logic [1:0]        fsm_state;

  data_memory_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .SP_RESET((1 << ADDR_W) - 1)
  ) dut (
    .clk(clk), .rst(rst),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_push(memory_push), .memory_pop(memory_pop),
    .address(address), .write_data(write_data),
    .data_r(data_r), .busy(busy), .done(done), .op_error(op_error),
    .sp_out(sp_out), .stack_fault(stack_fault), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        ops;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] exp_sp;
  } vec_t;

  vec_t              vecs [9];
  logic [DATA_W-1:0] exp_q [$];
  int                total  = 0;
  int                passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_ops(input logic [3:0] ops, input logic [15:0] a, input logic [DATA_W-1:0] d);
    {memory_read, memory_write, memory_push, memory_pop} = ops;
    address    = a;
    write_data = d;
  endtask

  // Issues one transaction and reports the cycle of done (counted from the accepting
  // edge), how many cycles busy was seen, and stack_fault sampled with done.
  task automatic run_op(input logic [3:0] ops, input logic [15:0] a, input logic [DATA_W-1:0] d,
                        output int done_cyc, output int busy_cyc, output logic fault);
    @(negedge clk);
    drive_ops(ops, a, d);
    @(posedge clk);
    @(negedge clk);
    drive_ops(4'b0000, 16'h0000, '0);
    done_cyc = 0;
    busy_cyc = 0;
    fault    = 1'b0;
    for (int i = 1; i <= LATENCY + 6; i++) begin
      if (done) begin
        done_cyc = i;
        fault    = stack_fault;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc;
    int   bc;
    logic flt;
    int   seen_done;
    int   seen_busy;

    vecs[0] = '{OP_WR,   16'h0010, 16'hBEEF, 16'h0000, 11'h7FF};
    vecs[1] = '{OP_RD,   16'h0010, 16'h0000, 16'hBEEF, 11'h7FF};
    vecs[2] = '{OP_RD,   16'hF810, 16'h0000, 16'hBEEF, 11'h7FF};
    vecs[3] = '{OP_PUSH, 16'h0000, 16'h1111, 16'hBEEF, 11'h7FE};
    vecs[4] = '{OP_PUSH, 16'h0000, 16'h2222, 16'hBEEF, 11'h7FD};
    vecs[5] = '{OP_POP,  16'h0000, 16'h0000, 16'h2222, 11'h7FE};
    vecs[6] = '{OP_POP,  16'h0000, 16'h0000, 16'h1111, 11'h7FF};
    vecs[7] = '{OP_WR,   16'h0020, 16'h5555, 16'h1111, 11'h7FF};
    vecs[8] = '{OP_WR,   16'h0000, 16'h0A0B, 16'h1111, 11'h7FF};

    rst = 1'b1;
    drive_ops(4'b0000, 16'h0000, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset data_r", 32'(data_r), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset op_error", 32'(op_error), 32'h0);
    check("reset stack_fault", 32'(stack_fault), 32'h0);
    check("reset sp_out", 32'(sp_out), 32'h7FF);
    check("reset state", 32'(fsm_state), 32'h0);

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(vecs[i].exp_data);
      run_op(vecs[i].ops, vecs[i].addr, vecs[i].wdata, dc, bc, flt);
      check($sformatf("vec%0d done cycle", i), 32'(dc), 32'(LATENCY + 1));
      check($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(LATENCY));
      check($sformatf("vec%0d data_r", i), 32'(data_r), 32'(exp_q.pop_front()));
      check($sformatf("vec%0d sp_out", i), 32'(sp_out), 32'(vecs[i].exp_sp));
      check($sformatf("vec%0d stack_fault", i), 32'(flt), 32'h0);
    end

    // done lasts one cycle and the FSM is back in IDLE
    @(negedge clk);
    check("done one cycle", 32'(done), 32'h0);
    check("idle after done", 32'(fsm_state), 32'h0);

    // Conflicting read+push for one cycle
    drive_ops(OP_RD | OP_PUSH, 16'h07FF, 16'hDEAD);
    @(posedge clk);
    @(negedge clk);
    drive_ops(4'b0000, 16'h0000, '0);
    check("conflict op_error", 32'(op_error), 32'h1);
    check("conflict busy", 32'(busy), 32'h0);
    check("conflict state", 32'(fsm_state), 32'h0);
    @(negedge clk);
    check("conflict op_error pulse", 32'(op_error), 32'h0);
    check("conflict busy later", 32'(busy), 32'h0);
    check("conflict sp_out", 32'(sp_out), 32'h7FF);
    run_op(OP_RD, 16'h07FF, 16'h0000, dc, bc, flt);
    check("conflict ram unchanged", 32'(data_r), 32'h1111);

    // Reset during the first ACCESS cycle of a write
    @(negedge clk);
    drive_ops(OP_WR, 16'h0020, 16'hAAAA);
    @(posedge clk);
    @(negedge clk);
    drive_ops(4'b0000, 16'h0000, '0);
    check("midop busy before reset", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < LATENCY + 3; i++) begin
      if (done) seen_done++;
      if (busy) seen_busy++;
      @(negedge clk);
    end
    check("midop no done", 32'(seen_done), 32'h0);
    check("midop no busy", 32'(seen_busy), 32'h0);
    check("midop sp_out", 32'(sp_out), 32'h7FF);
    run_op(OP_RD, 16'h0020, 16'h0000, dc, bc, flt);
    check("midop ram kept", 32'(data_r), 32'h5555);

    // Pop on an empty stack
    run_op(OP_POP, 16'h0000, 16'h0000, dc, bc, flt);
    check("empty pop done cycle", 32'(dc), 32'(LATENCY + 1));
`ifdef STACK_BOUNDS_CHECK_EN
    check("empty pop fault", 32'(flt), 32'h1);
    check("empty pop sp_out", 32'(sp_out), 32'h7FF);
    check("empty pop data_r", 32'(data_r), 32'h5555);
`else
    check("empty pop fault", 32'(flt), 32'h0);
    check("empty pop sp_out", 32'(sp_out), 32'h000);
    check("empty pop data_r", 32'(data_r), 32'h0A0B);
    // Push at SP==0 wraps to the top; the next pop reads mem[0] back
    run_op(OP_PUSH, 16'h0000, 16'h3333, dc, bc, flt);
    check("wrap push fault", 32'(flt), 32'h0);
    check("wrap push sp_out", 32'(sp_out), 32'h7FF);
    run_op(OP_POP, 16'h0000, 16'h0000, dc, bc, flt);
    check("wrap pop data_r", 32'(data_r), 32'h3333);
    check("wrap pop sp_out", 32'(sp_out), 32'h000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
